fc_obuf: RTL and testbench

- Output buffer of an FC layer; the transmit end of the inter-layer channel into the next layer's input buffer.
- Collects bit-serial crossbar column sums (one bit-plane per pass, LSB first) and shift-accumulates them per output element.
- Requantizes each element to DATA_SIZE bits.
- Streams elements out NUM_CHANNELS at a time with a write strobe that drives the downstream input-buffer write enable.

---
 rtl/fc_pkg.sv | 39 +++
 rtl/fc_obuf_acc_lane.sv | 60 ++++++
 rtl/fc_obuf.sv | 127 ++++++++++++
 tb/tb_fc_obuf.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_pkg.sv
// Shared FC-layer definitions: output-buffer FSM states, channel geometry helpers
// used by both the input and output buffers, and the output requantizer.
package fc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    XMIT
  } obuf_state_t;

  function automatic int unsigned obuf_data_size(input int unsigned data_size,
                                                 input int unsigned xbar_size);
    return (data_size == 1) ? $clog2(xbar_size) : 2 * data_size + $clog2(xbar_size);
  endfunction

  function automatic int unsigned num_channels(input int unsigned bus_width,
                                               input int unsigned obuf_dsize);
    return bus_width / obuf_dsize;
  endfunction

  function automatic int unsigned fifo_length(input int unsigned xbar_size,
                                              input int unsigned data_size,
                                              input int unsigned nch);
    return ((xbar_size / data_size) + nch - 1) / nch;
  endfunction

  // Negative inputs clamp to zero, then shift right and saturate to dsize bits.
  function automatic logic [31:0] requantize(input logic signed [63:0] x,
                                             input int unsigned shift,
                                             input int unsigned dsize);
    logic signed [63:0] v;
    logic signed [63:0] maxv;
    v    = (x < 0) ? '0 : x;
    v    = v >>> shift;
    maxv = (64'sd1 <<< dsize) - 64'sd1;
    return (v > maxv) ? maxv[31:0] : v[31:0];
  endfunction

endpackage

// File: rtl/fc_obuf_acc_lane.sv
// One output channel: FIFO_LENGTH shift-accumulators plus the read-side requantizer.
// FC_OBUF_SIGNED_EN: signed accumulation, MSB bit-plane subtracted.
module fc_obuf_acc_lane
  import fc_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned OBUF_DATA_SIZE = 23,
  parameter int unsigned FIFO_LENGTH    = 8,
  parameter int unsigned ACC_WIDTH      = 31,
  parameter int unsigned OUT_SHIFT      = 8,
  parameter int unsigned BIT_W          = 3,
  parameter int unsigned ADDR_W         = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clear,
  input  logic                      en,
  input  logic [BIT_W-1:0]          bit_idx,
  input  logic [ADDR_W-1:0]         addr,
  input  logic [OBUF_DATA_SIZE-1:0] sum,
  input  logic [ADDR_W-1:0]         rd_ptr,
  output logic [DATA_SIZE-1:0]      q
);

  logic [ACC_WIDTH-1:0] acc [FIFO_LENGTH];
  logic [ACC_WIDTH-1:0] addend;
  logic [ACC_WIDTH-1:0] rd;
  logic signed [63:0]   rd_ext;
  logic [31:0]          q_wide;
  logic                 unused_q_hi;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc <= '{default: '0};
    end else if (en && (32'(addr) < FIFO_LENGTH)) begin
`ifdef FC_OBUF_SIGNED_EN
      if (32'(bit_idx) == DATA_SIZE - 1) acc[addr] <= acc[addr] - addend;
      else                               acc[addr] <= acc[addr] + addend;
`else
      acc[addr] <= acc[addr] + addend;
`endif
    end
  end

  always_comb begin
    addend = ACC_WIDTH'(sum) << bit_idx;
    rd     = acc[rd_ptr];
`ifdef FC_OBUF_SIGNED_EN
    rd_ext = {{(64-ACC_WIDTH){rd[ACC_WIDTH-1]}}, rd};
`else
    rd_ext = {{(64-ACC_WIDTH){1'b0}}, rd};
`endif
    q_wide = requantize(rd_ext, OUT_SHIFT, DATA_SIZE);
  end

  // requantize saturates to DATA_SIZE bits, so the upper result bits are always zero
  assign q           = q_wide[DATA_SIZE-1:0];
  assign unused_q_hi = ^q_wide[31:DATA_SIZE];

endmodule

// File: rtl/fc_obuf.sv
// FC-layer output buffer: bit-serial shift-accumulate, requantize, stream to next layer.
// FC_OBUF_SIGNED_EN selects the signed datapath with ReLU requantization.
module fc_obuf
  import fc_pkg::*;
#(
  parameter int unsigned DATA_SIZE      = 8,
  parameter int unsigned XBAR_SIZE      = 128,
  parameter int unsigned OBUF_BUS_WIDTH = 46,
  parameter int unsigned OUT_SHIFT      = 8,
  localparam int unsigned OBUF_DATA_SIZE = obuf_data_size(DATA_SIZE, XBAR_SIZE),
  localparam int unsigned NUM_CHANNELS   = num_channels(OBUF_BUS_WIDTH, OBUF_DATA_SIZE),
  localparam int unsigned FIFO_LENGTH    = fifo_length(XBAR_SIZE, DATA_SIZE, NUM_CHANNELS),
  localparam int unsigned ACC_WIDTH      = OBUF_DATA_SIZE + DATA_SIZE,
  localparam int unsigned BIT_W          = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1,
  localparam int unsigned ADDR_W         = (FIFO_LENGTH > 1) ? $clog2(FIFO_LENGTH) : 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                i_start,
  input  logic                                i_valid,
  input  logic [BIT_W-1:0]                    i_bit,
  input  logic [ADDR_W-1:0]                   i_addr,
  input  logic [OBUF_BUS_WIDTH-1:0]           i_data,
  input  logic                                i_last,
  input  logic                                i_ds_ready,
  output logic                                o_we,
  output logic [DATA_SIZE*NUM_CHANNELS-1:0]   o_data,
  output logic                                o_busy,
  output logic                                o_done
);

  localparam logic [ADDR_W-1:0] PTR_LAST = ADDR_W'(FIFO_LENGTH - 1);

  obuf_state_t                       state, state_d;
  logic [ADDR_W-1:0]                 ptr, ptr_d;
  logic                              fin, fin_d;
  logic                              we_d, done_d;
  logic                              clear, en;
  logic [DATA_SIZE*NUM_CHANNELS-1:0] data_d, q_all;

  for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_lane
    fc_obuf_acc_lane #(
      .DATA_SIZE      (DATA_SIZE),
      .OBUF_DATA_SIZE (OBUF_DATA_SIZE),
      .FIFO_LENGTH    (FIFO_LENGTH),
      .ACC_WIDTH      (ACC_WIDTH),
      .OUT_SHIFT      (OUT_SHIFT),
      .BIT_W          (BIT_W),
      .ADDR_W         (ADDR_W)
    ) u_lane (
      .clk     (clk),
      .rst     (rst),
      .clear   (clear),
      .en      (en),
      .bit_idx (i_bit),
      .addr    (i_addr),
      .sum     (i_data[c*OBUF_DATA_SIZE +: OBUF_DATA_SIZE]),
      .rd_ptr  (ptr),
      .q       (q_all[c*DATA_SIZE +: DATA_SIZE])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= PTR_LAST;
      fin    <= 1'b0;
      o_we   <= 1'b0;
      o_done <= 1'b0;
      o_data <= '0;
    end else begin
      state  <= state_d;
      ptr    <= ptr_d;
      fin    <= fin_d;
      o_we   <= we_d;
      o_done <= done_d;
      o_data <= data_d;
    end
  end

  // fin marks that the slot-0 beat is on the bus; o_done is raised the cycle after it.
  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    fin_d   = fin;
    we_d    = 1'b0;
    done_d  = 1'b0;
    data_d  = o_data;
    clear   = 1'b0;
    en      = 1'b0;
    unique case (state)
      IDLE: begin
        ptr_d = PTR_LAST;
        fin_d = 1'b0;
        if (i_start) begin
          clear   = 1'b1;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (i_start) begin
          clear = 1'b1;
        end else begin
          en = i_valid;
          if (i_last) state_d = XMIT;
        end
      end
      XMIT: begin
        if (fin) begin
          done_d  = 1'b1;
          fin_d   = 1'b0;
          ptr_d   = PTR_LAST;
          state_d = IDLE;
        end else if (i_ds_ready) begin
          we_d   = 1'b1;
          data_d = q_all;
          if (ptr == '0) fin_d = 1'b1;
          else           ptr_d = ptr - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign o_busy = (state == ACCUM) || (state == XMIT);

endmodule

// File: tb/tb_fc_obuf.sv
// Scoreboard bench for fc_obuf: two instances (OUT_SHIFT 0 and default 8) share stimulus.
// The reference keeps plain integer accumulators and requantizes from the arithmetic rules.
module tb_fc_obuf;

  localparam int NCH = 2;
  localparam int FL  = 8;
  localparam int ODS = 23;
  localparam int DS  = 8;
  localparam longint ACC_MASK = (longint'(1) << 31) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_start = 1'b0, i_valid = 1'b0, i_last = 1'b0, i_ds_ready = 1'b1;
  logic [2:0]  i_bit = '0, i_addr = '0;
  logic [45:0] i_data = '0;
  logic        o_we0, o_busy0, o_done0, o_we8, o_busy8, o_done8;
  logic [15:0] o_data0, o_data8;

  int checks = 0;
  int errors = 0;
  longint macc [NCH][FL];
  logic [15:0] exp0[$];
  logic [15:0] exp8[$];
  int   nb0 = 0, nb8 = 0;
  logic pw0 = 1'b0, pw8 = 1'b0;

  always #5 clk = ~clk;

  fc_obuf #(.OUT_SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_bit(i_bit),
    .i_addr(i_addr), .i_data(i_data), .i_last(i_last), .i_ds_ready(i_ds_ready),
    .o_we(o_we0), .o_data(o_data0), .o_busy(o_busy0), .o_done(o_done0)
  );

  fc_obuf dut8 (
    .clk(clk), .rst(rst), .i_start(i_start), .i_valid(i_valid), .i_bit(i_bit),
    .i_addr(i_addr), .i_data(i_data), .i_last(i_last), .i_ds_ready(i_ds_ready),
    .o_we(o_we8), .o_data(o_data8), .o_busy(o_busy8), .o_done(o_done8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  function automatic logic [7:0] mq(input longint a, input int sh);
    longint v;
    v = a & ACC_MASK;
`ifdef FC_OBUF_SIGNED_EN
    if (v >= (longint'(1) << 30)) v = v - (longint'(1) << 31);
    if (v < 0) v = 0;
`endif
    v = v >> sh;
    if (v > 255) v = 255;
    return 8'(v);
  endfunction

  function automatic void m_clear();
    foreach (macc[c, k]) macc[c][k] = 0;
  endfunction

  function automatic void m_add(input int a, input int b, input int s0, input int s1);
    longint t;
    for (int c = 0; c < NCH; c++) begin
      t = longint'((c == 0) ? s0 : s1) << b;
`ifdef FC_OBUF_SIGNED_EN
      if (b == DS - 1) t = -t;
`endif
      macc[c][a] = (macc[c][a] + t) & ACC_MASK;
    end
  endfunction

  function automatic void push_stream();
    for (int k = FL - 1; k >= 0; k--) begin
      exp0.push_back({mq(macc[1][k], 0), mq(macc[0][k], 0)});
      exp8.push_back({mq(macc[1][k], 8), mq(macc[0][k], 8)});
    end
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      nb0 = 0; nb8 = 0; pw0 = 1'b0; pw8 = 1'b0;
    end else begin
      if (o_we0) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat0: o_data=0x%0h with nothing expected", o_data0);
        end else check("beat_shift0", o_data0, exp0.pop_front());
        nb0++;
      end
      if (o_done0) begin
        check("done_after_last0", pw0, 1);
        check("beat_count0", nb0, FL);
        nb0 = 0;
      end
      pw0 = o_we0;
      if (o_we8) begin
        if (exp8.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_beat8: o_data=0x%0h with nothing expected", o_data8);
        end else check("beat_shift8", o_data8, exp8.pop_front());
        nb8++;
      end
      if (o_done8) begin
        check("done_after_last8", pw8, 1);
        check("beat_count8", nb8, FL);
        nb8 = 0;
      end
      pw8 = o_we8;
    end
  end

  task automatic do_start(input bit with_valid);
    i_start = 1'b1;
    i_valid = with_valid;
    i_data  = {ODS'($urandom), ODS'($urandom)};
    m_clear();
    @(negedge clk);
    i_start = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic send(input int a, input int b, input int s0, input int s1, input bit last);
    i_valid = 1'b1;
    i_addr  = 3'(a);
    i_bit   = 3'(b);
    i_data  = {ODS'(s1), ODS'(s0)};
    i_last  = last;
    m_add(a, b, s0, s1);
    @(negedge clk);
    i_valid = 1'b0;
    i_last  = 1'b0;
    if (last) push_stream();
  endtask

  task automatic last_only();
    i_last = 1'b1;
    @(negedge clk);
    i_last = 1'b0;
    push_stream();
  endtask

  task automatic junk_beat();
    i_valid = 1'b1;
    i_addr  = 3'($urandom);
    i_bit   = 3'($urandom);
    i_data  = {ODS'($urandom), ODS'($urandom)};
    @(negedge clk);
    i_valid = 1'b0;
  endtask

  task automatic wait_done(input bit noisy);
    bit seen = 1'b0;
    for (int i = 0; i < 300 && !seen; i++) begin
      if (noisy) begin
        i_ds_ready = 1'($urandom_range(0, 1));
        i_valid    = 1'($urandom_range(0, 1));
        i_start    = 1'($urandom_range(0, 1));
        i_data     = {ODS'($urandom), ODS'($urandom)};
      end
      @(negedge clk);
      if (o_done0) seen = 1'b1;
    end
    i_ds_ready = 1'b1;
    i_valid    = 1'b0;
    i_start    = 1'b0;
    check("stream_done", seen, 1);
  endtask

  task automatic wait_beats(input int n);
    int seen = 0;
    for (int i = 0; i < 100 && seen < n; i++) begin
      @(negedge clk);
      if (o_we0) seen++;
    end
    check("beats_reached", seen, n);
  endtask

  initial begin
    m_clear();
    repeat (3) @(negedge clk);
    check("rst_we", o_we0, 0);
    check("rst_busy", o_busy0, 0);
    check("rst_done", o_done0, 0);
    check("rst_data0", o_data0, 0);
    check("rst_data8", o_data8, 0);
    rst = 1'b0;
    @(negedge clk);

    // valid while idle must not touch the accumulators
    junk_beat();
    check("idle_busy", o_busy0, 0);

    do_start(0);
    check("accum_busy", o_busy8, 1);
    send(3, 0, 5, 0, 0);
    send(3, 1, 3, 0, 1);
    wait_done(0);

    do_start(0);
    send(0, 7, 200, 0, 1);
    wait_done(0);

    do_start(0);
    send(5, 7, 1, 0, 0);
    send(5, 0, 100, 0, 1);
    wait_done(0);

    do_start(0);
    for (int k = 0; k < FL; k++) send(k, 0, 0, k + 1, k == FL - 1);
    wait_done(0);

    // downstream stall after beat 2
    do_start(0);
    for (int k = 0; k < FL; k++) send(k, 0, 0, k + 1, k == FL - 1);
    wait_beats(2);
    i_ds_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("stall_low", o_we0, 0);
    end
    i_ds_ready = 1'b1;
    @(negedge clk);
    check("stall_resume", o_we0, 1);
    wait_done(0);

    // reset in the middle of a stream
    do_start(0);
    for (int k = 0; k < FL; k++)
      send(k, $urandom_range(0, 7), $urandom_range(0, 'h7FFFFF), $urandom_range(0, 'h7FFFFF),
           k == FL - 1);
    wait_beats(4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_we", o_we0, 0);
    check("midrst_busy", o_busy0, 0);
    check("midrst_data", o_data8, 0);
    exp0.delete();
    exp8.delete();
    m_clear();
    @(negedge clk);
    rst = 1'b0;
    do_start(0);
    last_only();
    wait_done(0);

    for (int t = 0; t < 8; t++) begin
      junk_beat();
      do_start(1'($urandom_range(0, 1)));
      for (int j = 0, n = $urandom_range(3, 20); j < n; j++) begin
        if ($urandom_range(0, 9) == 0) do_start(1);
        else send($urandom_range(0, FL - 1), $urandom_range(0, DS - 1),
                  $urandom_range(0, 'h7FFFFF), $urandom_range(0, 'h7FFFFF), 0);
      end
      if ($urandom_range(0, 1) == 1)
        send($urandom_range(0, FL - 1), $urandom_range(0, DS - 1),
             $urandom_range(0, 'h7FFFFF), $urandom_range(0, 'h7FFFFF), 1);
      else last_only();
      wait_done(1);
    end

    repeat (3) @(negedge clk);
    check("queues_drained", exp0.size() + exp8.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
